// File: rtl/score_counter_pkg.sv
// Shared BCD definitions for the score counter and the per-digit renderers.
package score_counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  function automatic logic bcd_is_max(input bcd_digit_t d);
    return (d == BCD_MAX);
  endfunction

endpackage

// File: rtl/score_counter_bcd_digit.sv
// Single decade counter: counts 0..9 on inc_in, rolls to 0 with a carry.
// hold freezes the digit so a saturated score never wraps.
module score_counter_bcd_digit
  import score_counter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_inc_in,
  input  logic       i_clear,
  input  logic       i_hold,
  output bcd_digit_t o_digit,
  output logic       o_carry_out
);

  bcd_digit_t r_digit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digit <= '0;
    end else if (i_clear) begin
      r_digit <= '0;
    end else if (i_inc_in && !i_hold) begin
      if (bcd_is_max(r_digit)) begin
        r_digit <= '0;
      end else begin
        r_digit <= r_digit + 4'd1;
      end
    end
  end

  assign o_digit     = r_digit;
  assign o_carry_out = i_inc_in & bcd_is_max(r_digit);

endmodule

// File: rtl/score_counter.sv
// Packed-BCD game score with a frame-stable display copy.
// Define SCORE_COUNTER_HISCORE_EN to add the session high-score register.
module score_counter
  import score_counter_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_point,
  input  logic                  i_clear,
  input  logic                  i_frame_tick,
  output logic [4*DIGITS-1:0]   o_score_bcd,
  output logic [4*DIGITS-1:0]   o_hiscore_bcd,
  output logic                  o_saturated,
  output logic                  o_new_high
);

  logic                      r_point_q;
  logic                      w_inc;
  logic                      w_hold;
  logic [DIGITS-1:0]         w_inc_in;
  logic [DIGITS-1:0]         w_carry;
  logic [DIGITS-1:0]         w_is_max;
  logic [BCD_W*DIGITS-1:0]   w_count;
  logic [BCD_W*DIGITS-1:0]   r_score_bcd;
  logic                      r_saturated;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_point_q <= 1'b0;
    end else begin
      r_point_q <= i_point;
    end
  end

  assign w_inc  = i_point & ~r_point_q;
  assign w_hold = &w_is_max;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign w_inc_in[gi] = w_inc;
      end else begin : g_upper
        assign w_inc_in[gi] = w_carry[gi-1];
      end

      score_counter_bcd_digit u_digit (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_inc_in    (w_inc_in[gi]),
        .i_clear     (i_clear),
        .i_hold      (w_hold),
        .o_digit     (w_count[gi*BCD_W +: BCD_W]),
        .o_carry_out (w_carry[gi])
      );

      assign w_is_max[gi] = bcd_is_max(w_count[gi*BCD_W +: BCD_W]);
    end
  endgenerate

  // A carry out of the top digit can only happen while held at all nines.
  a_top_carry_only_when_saturated : assert property (
    @(posedge i_clk) disable iff (!i_rst_n) w_carry[DIGITS-1] |-> w_hold
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_score_bcd <= '0;
      r_saturated <= 1'b0;
    end else begin
      r_saturated <= w_hold;
      if (i_frame_tick) begin
        r_score_bcd <= w_count;
      end
    end
  end

  assign o_score_bcd = r_score_bcd;
  assign o_saturated = r_saturated;

`ifdef SCORE_COUNTER_HISCORE_EN
  logic [BCD_W*DIGITS-1:0] r_hiscore;
  logic [BCD_W*DIGITS-1:0] r_hiscore_bcd;
  logic                    r_new_high;
  logic                    w_above;

  // Valid BCD orders the same as plain unsigned binary.
  assign w_above = (w_count > r_hiscore);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hiscore     <= '0;
      r_hiscore_bcd <= '0;
      r_new_high    <= 1'b0;
    end else begin
      r_new_high <= w_above;
      if (w_above) begin
        r_hiscore <= w_count;
      end
      if (i_frame_tick) begin
        r_hiscore_bcd <= r_hiscore;
      end
    end
  end

  assign o_hiscore_bcd = r_hiscore_bcd;
  assign o_new_high    = r_new_high;
`else
  assign o_hiscore_bcd = '0;
  assign o_new_high    = 1'b0;
`endif

endmodule

// File: tb/tb_score_counter.sv
// Directed self-checking bench for score_counter (default and hiscore builds).
module tb_score_counter;

  localparam int DIGITS = 3;

  logic                clk;
  logic                rst_n;
  logic                point;
  logic                clear;
  logic                frame_tick;
  logic [4*DIGITS-1:0] score_bcd;
  logic [4*DIGITS-1:0] hiscore_bcd;
  logic                saturated;
  logic                new_high;

  int n_checks = 0;
  int n_errors = 0;

  score_counter #(.DIGITS(DIGITS)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_point      (point),
    .i_clear      (clear),
    .i_frame_tick (frame_tick),
    .o_score_bcd  (score_bcd),
    .o_hiscore_bcd(hiscore_bcd),
    .o_saturated  (saturated),
    .o_new_high   (new_high)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      point = 1'b1;
      step();
      point = 1'b0;
      step();
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; point = 1'b0; clear = 1'b0; frame_tick = 1'b0;
    #12;
    check("rst_score", 32'(score_bcd), 32'h000);
    check("rst_hiscore", 32'(hiscore_bcd), 32'h000);
    check("rst_saturated", 32'(saturated), 32'h0);
    check("rst_new_high", 32'(new_high), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Ones roll over into tens.
    pulse(10);
    tick();
    check("rollover_010", 32'(score_bcd), 32'h010);

    // Level held high scores exactly once.
    point = 1'b1;
    repeat (100) step();
    point = 1'b0;
    step();
    tick();
    check("held_level_011", 32'(score_bcd), 32'h011);

    // clear, point rise and frame_tick on the same edge.
    pulse(1);
    point = 1'b1; clear = 1'b1; frame_tick = 1'b1;
    step();
    clear = 1'b0; frame_tick = 1'b0;
    check("clear_shows_preclear", 32'(score_bcd), 32'h012);
    repeat (3) step();
    point = 1'b0;
    step();
    tick();
    check("clear_then_zero", 32'(score_bcd), 32'h000);

    // High-score behaviour.
    pulse(42);
    clear = 1'b1;
    step();
    clear = 1'b0;
    pulse(17);
    tick();
    check("score_017", 32'(score_bcd), 32'h017);
    check("new_high_below", 32'(new_high), 32'h0);
`ifdef SCORE_COUNTER_HISCORE_EN
    check("hiscore_042", 32'(hiscore_bcd), 32'h042);
`else
    check("hiscore_off_zero", 32'(hiscore_bcd), 32'h000);
`endif
    pulse(25);
    point = 1'b1;
    step();
    check("new_high_equal_prev", 32'(new_high), 32'h0);
    step();
    point = 1'b0;
`ifdef SCORE_COUNTER_HISCORE_EN
    check("new_high_43", 32'(new_high), 32'h1);
`else
    check("new_high_off", 32'(new_high), 32'h0);
`endif
    step();
    tick();
    check("score_043", 32'(score_bcd), 32'h043);
`ifdef SCORE_COUNTER_HISCORE_EN
    check("hiscore_043", 32'(hiscore_bcd), 32'h043);
`else
    check("hiscore_off_043", 32'(hiscore_bcd), 32'h000);
`endif

    // Saturation at 999.
    clear = 1'b1;
    step();
    clear = 1'b0;
    pulse(998);
    tick();
    check("score_998", 32'(score_bcd), 32'h998);
    check("sat_998", 32'(saturated), 32'h0);
    point = 1'b1;
    step();
    check("sat_lag", 32'(saturated), 32'h0);
    step();
    check("sat_set", 32'(saturated), 32'h1);
    point = 1'b0;
    step();
    pulse(1);
    tick();
    check("score_stays_999", 32'(score_bcd), 32'h999);
    check("sat_held", 32'(saturated), 32'h1);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_score", 32'(score_bcd), 32'h000);
    check("async_hiscore", 32'(hiscore_bcd), 32'h000);
    check("async_sat", 32'(saturated), 32'h0);
    check("async_new_high", 32'(new_high), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // frame_tick and inc on the same edge: display gets old value.
    point = 1'b1; frame_tick = 1'b1;
    step();
    point = 1'b0; frame_tick = 1'b0;
    check("tick_inc_old", 32'(score_bcd), 32'h000);
    step();
    tick();
    check("tick_inc_new", 32'(score_bcd), 32'h001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
